// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
// Holds the default widths and the writeback request record.
package rf_pkg;

   localparam int REG_IDX_W   = 5;
   localparam int XLEN_DEF    = 32;
   localparam int NUM_REQ_DEF = 3;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN_DEF-1:0]  data;
   } wb_req_t;

   // Successor of idx in a ring of n slots.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: NUM_REQ-wide request vector in, one-hot grant out.
// The search starts at the internal pointer, which moves just past each winner.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int N = NUM_REQ_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);

   localparam int PTR_W = (N > 2) ? 2 : 1;

   logic [PTR_W-1:0] rr_ptr_q;
   logic [PTR_W-1:0] rr_ptr_d;

   always_comb begin
      int unsigned pos;
      logic        found;
      // NOTE: every output gets a default before the loop, so no path leaves one unassigned (no latch).
      gnt_o    = '0;
      rr_ptr_d = rr_ptr_q;
      found    = 1'b0;
      pos      = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = (32'(rr_ptr_q) + k) % N;
         if (!found && !reset && req_i[pos[PTR_W-1:0]]) begin
            found                = 1'b1;
            gnt_o[pos[PTR_W-1:0]] = 1'b1;
            rr_ptr_d             = PTR_W'(wrap_inc(pos, N));
         end
      end
   end

   // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: picks one of NUM_REQ requests per cycle and registers it onto the RF write port.
// Optional feature: define RF_WB_BYPASS_EN to add two combinational bypass lookup ports.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*REG_IDX_W-1:0] req_rd,
   input  logic [NUM_REQ*XLEN-1:0]      req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         rf_we,
   output logic [REG_IDX_W-1:0]         rf_rd,
   output logic [XLEN-1:0]              rf_wdata,
`ifdef RF_WB_BYPASS_EN
   input  logic [REG_IDX_W-1:0]         byp_rs1,
   input  logic [REG_IDX_W-1:0]         byp_rs2,
   output logic                         byp_hit1,
   output logic                         byp_hit2,
   output logic [XLEN-1:0]              byp_data1,
   output logic [XLEN-1:0]              byp_data2,
`endif
   output logic [15:0]                  conflict_cnt
);

   logic [NUM_REQ-1:0]   gnt;
   logic                 accept;
   logic                 conflict;
   logic [REG_IDX_W-1:0] sel_rd;
   logic [XLEN-1:0]      sel_data;

   logic                 rf_we_q, rf_we_d;
   logic [REG_IDX_W-1:0] rf_rd_q;
   logic [XLEN-1:0]      rf_wdata_q;
   logic [15:0]          conflict_cnt_q;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk   (clk),
      .reset (reset),
      .req_i (req_valid),
      .gnt_o (gnt)
   );

   assign req_ready = gnt;
   assign accept    = |gnt;
   assign conflict  = $countones(req_valid) >= 2;

   // Grant is one-hot, so an AND-OR select picks the winner's payload.
   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_rd   = req_rd[REG_IDX_W*i +: REG_IDX_W];
            sel_data = req_data[XLEN*i +: XLEN];
         end
      end
   end

   // Writes to x0 are accepted from the requester but never reach the port.
   assign rf_we_d = accept && (sel_rd != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q <= rf_we_d;
         if (rf_we_d) begin
            rf_rd_q    <= sel_rd;
            rf_wdata_q <= sel_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflict_cnt_q <= '0;
      end else if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
   end

   assign rf_we        = rf_we_q;
   assign rf_rd        = rf_rd_q;
   assign rf_wdata     = rf_wdata_q;
   assign conflict_cnt = conflict_cnt_q;

`ifdef RF_WB_BYPASS_EN
   always_comb begin
      byp_hit1  = rf_we_q && (rf_rd_q != '0) && (byp_rs1 == rf_rd_q);
      byp_hit2  = rf_we_q && (rf_rd_q != '0) && (byp_rs2 == rf_rd_q);
      byp_data1 = byp_hit1 ? rf_wdata_q : '0;
      byp_data2 = byp_hit2 ? rf_wdata_q : '0;
   end
`endif

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width of every writeback request and of the register-file write port.
REQ-002 Parameter: NUM_REQ, 3, number of writeback requesters; legal range 2..4.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester writeback request valid.
REQ-006 req_rd  input  NUM_REQ*5  per-requester destination register; requester i occupies bits [5i+4:5i].
REQ-007 req_data  input  NUM_REQ*XLEN  per-requester write data; requester i occupies bits [XLEN*i+XLEN-1:XLEN*i].
REQ-008 req_ready  output  NUM_REQ  one-hot accept; a request transfers on a cycle with valid and ready both high.
REQ-009 rf_we  output  1  register-file write enable.
REQ-010 rf_rd  output  5  register-file destination index.
REQ-011 rf_wdata  output  XLEN  register-file write data.
REQ-012 conflict_cnt  output  16  saturating count of cycles with two or more valid requests.
REQ-013 byp_rs1, byp_rs2  input  5 each  bypass lookup indices; present only with RF_WB_BYPASS_EN.
REQ-014 byp_hit1, byp_hit2  output  1 each  bypass match flags; present only with RF_WB_BYPASS_EN.
REQ-015 byp_data1, byp_data2  output  XLEN each  bypass data; present only with RF_WB_BYPASS_EN.

Function
REQ-016 Arbitration: round-robin; search starts at pointer rr_ptr and wraps through NUM_REQ-1 to 0; first valid requester found is granted.
REQ-017 req_ready is combinational, one-hot on the granted index, all-zero when no request is valid; requesters are never back-pressured beyond losing arbitration.
REQ-018 After a grant to index i, rr_ptr becomes (i+1) mod NUM_REQ on the next edge; with no grant, rr_ptr holds.
REQ-019 Output register: an accepted request appears on rf_we/rf_rd/rf_wdata exactly one cycle after acceptance and stays there for one cycle only.
REQ-020 Without an acceptance, rf_we is 0 on the next cycle; rf_rd and rf_wdata hold their last values.
REQ-021 A request with rd = 0 participates in arbitration and is accepted, but rf_we is 0 on the following cycle (the x0 write is discarded).
REQ-022 Throughput: one acceptance per cycle sustained; requests from different requesters to the same rd are committed in grant order.
REQ-023 conflict_cnt increments by 1 on each cycle where popcount(req_valid) >= 2 and saturates at 16'hFFFF.
REQ-024 Invalid requesters' req_rd and req_data are ignored.

Reset
REQ-025 While reset is asserted: rf_we=0, rf_rd=0, rf_wdata=0, rr_ptr=0, conflict_cnt=0, and req_ready=0 regardless of req_valid.
REQ-026 Reset asserted mid-operation discards any registered but uncommitted write; rf_we drops asynchronously.
REQ-027 First grant after reset release goes to the lowest-indexed valid requester.

Configuration
REQ-028 Macro RF_WB_BYPASS_EN defined: byp_hitN=1 and byp_dataN=rf_wdata when rf_we=1 and byp_rsN equals rf_rd (nonzero), combinationally; otherwise byp_hitN=0 and byp_dataN=0.
REQ-029 Macro RF_WB_BYPASS_EN undefined: the bypass ports and logic are absent; all other behaviour is identical.

Structure
REQ-030 Shared package rf_pkg holds REG_IDX_W=5, the default XLEN, the default NUM_REQ and the wb_req_t struct {rd, data}.
REQ-031 One sub-module, rr_arbiter (NUM_REQ-wide request in, one-hot grant out, pointer register inside), is instantiated once.

Verification
REQ-032 Single request: req_valid=3'b010, rd=5, data=32'hDEADBEEF -> req_ready=3'b010 the same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=32'hDEADBEEF.
REQ-033 All three requesters held valid for 6 cycles from reset -> grant order 0,1,2,0,1,2, and conflict_cnt=6.
REQ-034 Requester 2 is valid with rd=0 -> it is accepted (ready=3'b100), and rf_we stays 0 on the next cycle.
REQ-035 Reset is asserted on the cycle after an acceptance -> rf_we=0 immediately, and after release the first grant goes to requester 0.
REQ-036 With RF_WB_BYPASS_EN, rf_we=1, rf_rd=7, and byp_rs1=7, byp_rs2=0 -> byp_hit1=1 with byp_data1=rf_wdata, and byp_hit2=0.
REQ-037 Force conflict_cnt to 16'hFFFE and hold two valid requests for 3 cycles -> conflict_cnt stays at 16'hFFFF.
